// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : IF stage of the pipelined MIPS core. Holds the fetch PC,
//               runs the instruction-memory request/ack handshake and owns
//               the IF/ID pipeline register. Redirects coming back from the
//               D stage take effect only after the in-flight fetch (the
//               branch delay slot) has been delivered.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic        stall_D,
    input  logic        redirect_D,
    input  logic [31:0] npc_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
);

    // IDLE exists only for the single cycle after reset release, so the
    // first request never overlaps reset deassertion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // A redirect that arrives before the delay-slot fetch completes is
    // parked here until that fetch is delivered.
    logic        pend_v;
    logic [31:0] pend_tgt;

    // Word captured when memory answers while D is stalled.
    logic [31:0] fetch_buf;

    logic        in_req;
    logic        in_hold;
    logic        ack_in_req;
    logic        complete;
    logic        redirect_acc;
    logic        load_fetch;
    logic        load_buf;
    logic        load_bubble;
    logic        capture_buf;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Decode of the handshake into fetch-completion and redirect events.
    always_comb begin
        in_req       = (state == ST_REQ);
        in_hold      = (state == ST_HOLD);
        ack_in_req   = in_req & imem_ack;
        complete     = (ack_in_req | in_hold) & ~stall_D;
        redirect_acc = redirect_D & ~stall_D;
        load_fetch   = ack_in_req & ~stall_D;
        load_buf     = in_hold & ~stall_D;
        load_bubble  = in_req & ~imem_ack & ~stall_D;
        capture_buf  = ack_in_req & stall_D;
        pc_plus4     = pc_F + 32'd4;
        if (redirect_acc) begin
            next_pc = npc_D;
        end else if (pend_v) begin
            next_pc = pend_tgt;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // Fetch FSM next-state and request output; imem_req depends on state only.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = stall_D ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!stall_D) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_F;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC advances only when a fetch is handed to D.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F <= RESET_PC;
        end else if (complete) begin
            pc_F <= next_pc;
        end
    end

    // Pending redirect: parked while the delay slot is still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v   <= 1'b0;
            pend_tgt <= 32'd0;
        end else if (complete) begin
            pend_v   <= 1'b0;
        end else if (redirect_acc) begin
            pend_v   <= 1'b1;
            pend_tgt <= npc_D;
        end
    end

    // Capture of a returned word that D cannot accept yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_buf <= 32'd0;
        end else if (capture_buf) begin
            fetch_buf <= imem_rdata;
        end
    end

    // IF/ID pipeline register: load fetched/buffered word, bubble, or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= 32'd0;
            pc4_D   <= 32'd0;
            valid_D <= 1'b0;
        end else if (load_fetch) begin
            instr_D <= imem_rdata;
            pc_D    <= pc_F;
            pc4_D   <= pc_plus4;
            valid_D <= 1'b1;
        end else if (load_buf) begin
            instr_D <= fetch_buf;
            pc_D    <= pc_F;
            pc4_D   <= pc_plus4;
            valid_D <= 1'b1;
        end else if (load_bubble) begin
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_D = 1'b0;
    logic        redirect_D = 1'b0;
    logic [31:0] npc_D = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc4_D;
    logic        valid_D;

    int total = 0;
    int bad   = 0;

    if_fetch_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_D    (stall_D),
        .redirect_D (redirect_D),
        .npc_D      (npc_D),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_F       (pc_F),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc4_D      (pc4_D),
        .valid_D    (valid_D)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed, address-dependent word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    // started  : at least one clock seen since reset release
    // holding  : a word has been returned but D has not taken it
    // pending  : redirect target waiting for the delay slot to be handed over
    bit          m_started;
    bit          m_holding;
    logic [31:0] m_held_word;
    bit          m_pending;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4d;
    bit          m_valid;

    always @(posedge clk or negedge reset) begin
        bit          asking;
        bit          handed;
        bit          take_redirect;
        logic [31:0] word;
        if (!reset) begin
            m_started   = 1'b0;
            m_holding   = 1'b0;
            m_held_word = 32'd0;
            m_pending   = 1'b0;
            m_pend_tgt  = 32'd0;
            m_pc        = C_RESET_PC;
            m_instr     = C_NOP;
            m_pcd       = 32'd0;
            m_pc4d      = 32'd0;
            m_valid     = 1'b0;
        end else begin
            asking        = m_started && !m_holding;
            handed        = !stall_D && ((asking && imem_ack) || m_holding);
            take_redirect = redirect_D && !stall_D;
            if (handed) begin
                word    = m_holding ? m_held_word : imem_rdata;
                m_instr = word;
                m_pcd   = m_pc;
                m_pc4d  = m_pc + 32'd4;
                m_valid = 1'b1;
                if (take_redirect)  m_pc = npc_D;
                else if (m_pending) m_pc = m_pend_tgt;
                else                m_pc = m_pc + 32'd4;
                m_pending = 1'b0;
                m_holding = 1'b0;
            end else begin
                if (take_redirect) begin
                    m_pending  = 1'b1;
                    m_pend_tgt = npc_D;
                end
                if (asking && imem_ack) begin
                    m_holding   = 1'b1;
                    m_held_word = imem_rdata;
                end else if (asking && !stall_D) begin
                    m_instr = C_NOP;
                    m_valid = 1'b0;
                end
            end
            m_started = 1'b1;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        total++;
        if (imem_req !== (m_started && !m_holding)) begin
            bad++;
            $display("FAIL model_req t=%0t got=%b exp=%b", $time, imem_req, m_started && !m_holding);
        end
        total++;
        if (imem_addr !== m_pc || pc_F !== m_pc) begin
            bad++;
            $display("FAIL model_pc t=%0t addr=%h pc_F=%h exp=%h", $time, imem_addr, pc_F, m_pc);
        end
        total++;
        if (instr_D !== m_instr || pc_D !== m_pcd || pc4_D !== m_pc4d || valid_D !== m_valid) begin
            bad++;
            $display("FAIL model_ifid t=%0t got=%h/%h/%h/%b exp=%h/%h/%h/%b", $time,
                     instr_D, pc_D, pc4_D, valid_D, m_instr, m_pcd, m_pc4d, m_valid);
        end
    end

    // ---------------- literal checks and stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at negedge+1), then return at the
    // next negedge+1 so outputs reflect the intervening rising edge.
    task automatic step(input bit s, input bit r, input logic [31:0] n, input bit a);
        stall_D    = s;
        redirect_D = r;
        npc_D      = n;
        imem_ack   = a;
        imem_rdata = a ? mem_word(imem_addr) : $urandom;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rnd;
        bit          s;
        bit          r;
        bit          a;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_pc",     pc_F,              C_RESET_PC);
        check("rst_instr",  instr_D,           C_NOP);
        check("rst_pcd",    pc_D,              32'd0);
        check("rst_valid",  {31'd0, valid_D},  32'd0);
        reset = 1'b1;

        // Sequential fetch with zero-wait memory.
        step(0, 0, 0, 1);
        check("seq_req0",   {31'd0, imem_req}, 32'd1);
        check("seq_addr0",  imem_addr,         32'h0000_3000);
        step(0, 0, 0, 1);
        check("seq_addr1",  imem_addr,         32'h0000_3004);
        check("seq_instr0", instr_D,           mem_word(32'h0000_3000));
        check("seq_pcd0",   pc_D,              32'h0000_3000);
        check("seq_pc4d0",  pc4_D,             32'h0000_3004);
        check("seq_valid0", {31'd0, valid_D},  32'd1);
        step(0, 0, 0, 1);
        check("seq_addr2",  imem_addr,         32'h0000_3008);
        check("seq_pcd1",   pc_D,              32'h0000_3004);

        // Branch at 0x3004 in D: delay slot 0x3008 then target 0x3100.
        step(0, 1, 32'h0000_3100, 1);
        check("br_slot_pcd", pc_D,             32'h0000_3008);
        check("br_addr",     imem_addr,        32'h0000_3100);
        step(0, 0, 0, 1);
        check("br_tgt_pcd",  pc_D,             32'h0000_3100);
        check("br_addr2",    imem_addr,        32'h0000_3104);

        // Slow ack with a redirect pulse while waiting.
        step(0, 1, 32'h0000_3200, 0);
        check("slow_valid",  {31'd0, valid_D}, 32'd0);
        check("slow_instr",  instr_D,          C_NOP);
        check("slow_pcd",    pc_D,             32'h0000_3100);
        check("slow_addr0",  imem_addr,        32'h0000_3104);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("slow_addr2",  imem_addr,        32'h0000_3104);
        step(0, 0, 0, 1);
        check("slow_pcd2",   pc_D,             32'h0000_3104);
        check("slow_addr3",  imem_addr,        32'h0000_3200);

        // Stall coinciding with the ack of 0x3010.
        step(0, 1, 32'h0000_3010, 1);
        check("st_addr",     imem_addr,        32'h0000_3010);
        step(1, 0, 0, 1);
        check("st_req0",     {31'd0, imem_req}, 32'd0);
        check("st_pcd0",     pc_D,             32'h0000_3200);
        step(1, 0, 0, 1);
        check("st_req1",     {31'd0, imem_req}, 32'd0);
        check("st_pcd1",     pc_D,             32'h0000_3200);
        step(0, 0, 0, 0);
        check("st_instr",    instr_D,          mem_word(32'h0000_3010));
        check("st_pcd2",     pc_D,             32'h0000_3010);
        check("st_addr2",    imem_addr,        32'h0000_3014);
        check("st_req2",     {31'd0, imem_req}, 32'd1);

        // PC wrap from the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 1);
        check("wrap_addr0",  imem_addr,        32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wrap_pcd",    pc_D,             32'hFFFF_FFFC);
        check("wrap_pc4d",   pc4_D,            32'h0000_0000);
        check("wrap_addr1",  imem_addr,        32'h0000_0000);

        // Reset while a request is waiting; a late ack must be ignored.
        step(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("mrst_req",    {31'd0, imem_req}, 32'd0);
        check("mrst_pc",     pc_F,             C_RESET_PC);
        step(0, 0, 0, 1);
        check("mrst_req2",   {31'd0, imem_req}, 32'd0);
        check("mrst_valid",  {31'd0, valid_D}, 32'd0);
        check("mrst_instr",  instr_D,          C_NOP);
        reset = 1'b1;
        step(0, 0, 0, 0);
        check("mrst_req3",   {31'd0, imem_req}, 32'd1);
        check("mrst_addr",   imem_addr,        C_RESET_PC);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                #2 reset = 1'b0;
                step(0, 0, 0, 1);
                reset = 1'b1;
            end else begin
                s   = ($urandom_range(0, 99) < 25);
                a   = ($urandom_range(0, 99) < 60);
                r   = ($urandom_range(0, 99) < 10);
                rnd = $urandom;
                step(s, r, rnd & 32'hFFFF_FFFC, a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
